// File: rtl/niosii_oci_dct_trace_capture_pkg.sv
// Shared types and helpers for the Nios II OCI debug-core-trace capture buffer.
package niosii_oci_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } trace_state_e;

  // Elaboration-time ceil(log2(value)); value is expected to be >= 1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/niosii_oci_dct_trace_capture_if.sv
// Bundle of DCT sample, read-port and status signals around the trace capture buffer.
interface niosii_oci_dct_trace_capture_if
  import niosii_oci_pkg::*;
#(
  parameter int BUF_W  = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
);

  localparam int LVL_W = clog2(DEPTH) + 1;

  logic                   dct_valid;
  logic [BUF_W-1:0]       dct_buffer;
  logic [CNT_W-1:0]       dct_count;
  logic                   dct_stall;
  logic                   test_ending;
  logic                   test_has_ended;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [BUF_W+CNT_W-1:0] rd_data;
  logic [LVL_W-1:0]       fifo_level;
  logic [DROP_W-1:0]      drop_count;
  trace_state_e           trace_state;
  logic                   trace_done;

  // master = trace producer plus read-port consumer; slave = the capture buffer.
  modport master (
    output dct_valid, dct_buffer, dct_count, test_ending, test_has_ended, rd_ready,
    input  dct_stall, rd_valid, rd_data, fifo_level, drop_count, trace_state, trace_done
  );

  modport slave (
    input  dct_valid, dct_buffer, dct_count, test_ending, test_has_ended, rd_ready,
    output dct_stall, rd_valid, rd_data, fifo_level, drop_count, trace_state, trace_done
  );

endinterface

// File: rtl/niosii_oci_sync_fifo.sv
// First-word fall-through synchronous FIFO; full/empty come from an extra pointer wrap bit.
module niosii_oci_sync_fifo
  import niosii_oci_pkg::*;
#(
  parameter int W     = 34,
  parameter int DEPTH = 16,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  // Storage carries no reset; rd_data is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= wr_data;
  end

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level   = wptr - rptr;
  assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/niosii_oci_dct_trace_capture.sv
// DCT trace capture buffer: sample accept/drop logic, drop counter, RUN/FLUSH/DONE sequencer.
module niosii_oci_dct_trace_capture
  import niosii_oci_pkg::*;
#(
  parameter int BUF_W         = 30,
  parameter int CNT_W         = 4,
  parameter int DEPTH         = 16,
  parameter int STALL_ON_FULL = 0,
  parameter int DROP_W        = 16
) (
  input logic                            clk,
  input logic                            reset,
  niosii_oci_dct_trace_capture_if.slave  bus
);

  localparam int DATA_W = BUF_W + CNT_W;

  logic              full;
  logic              empty;
  logic              wr_req;
  logic              rd_fire;
  logic              wr_en;
  logic              drop;
  logic [DROP_W-1:0] drop_q;
  logic              done_q;
  trace_state_e      state;

  // A full FIFO still takes a sample when the head leaves in the same cycle.
  assign wr_req  = bus.dct_valid && (bus.dct_count != '0) && (state == RUN);
  assign rd_fire = bus.rd_valid && bus.rd_ready;
  assign wr_en   = wr_req && (!full || rd_fire);
  assign drop    = wr_req && full && !rd_fire && (STALL_ON_FULL == 0);

  niosii_oci_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data ({bus.dct_count, bus.dct_buffer}),
    .rd_en   (rd_fire),
    .rd_data (bus.rd_data),
    .full    (full),
    .empty   (empty),
    .level   (bus.fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= '0;
    end else if (drop && (drop_q != '1)) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      done_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.test_ending || bus.test_has_ended) state <= FLUSH;
        end
        FLUSH: begin
          if (empty && bus.test_has_ended) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.rd_valid    = !empty;
  assign bus.dct_stall   = (STALL_ON_FULL != 0) ? full : 1'b0;
  assign bus.drop_count  = drop_q;
  assign bus.trace_state = state;
  assign bus.trace_done  = done_q;

endmodule

// File: tb/tb_niosii_oci_dct_trace_capture.sv
// Randomised plus directed bench: a drop-mode and a stall-mode instance share stimulus and are checked against a list model.
module tb_niosii_oci_dct_trace_capture;
  import niosii_oci_pkg::*;

  localparam int DEPTH    = 16;
  localparam int DROP_MAX = 65535;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dct_valid = 1'b0;
  logic [29:0] dct_buf_v = '0;
  logic [3:0]  dct_cnt_v = '0;
  logic        rd_ready_v = 1'b0;
  logic        test_ending_v = 1'b0;
  logic        test_has_ended_v = 1'b0;

  int check_count = 0;
  int pass_count  = 0;

  // Model: per instance an ordered list of stored words, index 0 is the head.
  logic [33:0] mq [2][DEPTH];
  int          mcnt   [2];
  int          mdrop  [2];
  int          mstate [2];
  bit          mdone  [2];

  always #5 clk = ~clk;

  niosii_oci_dct_trace_capture_if #(.BUF_W(30), .CNT_W(4), .DEPTH(DEPTH), .DROP_W(16)) bus0 ();
  niosii_oci_dct_trace_capture_if #(.BUF_W(30), .CNT_W(4), .DEPTH(DEPTH), .DROP_W(16)) bus1 ();

  assign bus0.dct_valid      = dct_valid;
  assign bus0.dct_buffer     = dct_buf_v;
  assign bus0.dct_count      = dct_cnt_v;
  assign bus0.rd_ready       = rd_ready_v;
  assign bus0.test_ending    = test_ending_v;
  assign bus0.test_has_ended = test_has_ended_v;
  assign bus1.dct_valid      = dct_valid;
  assign bus1.dct_buffer     = dct_buf_v;
  assign bus1.dct_count      = dct_cnt_v;
  assign bus1.rd_ready       = rd_ready_v;
  assign bus1.test_ending    = test_ending_v;
  assign bus1.test_has_ended = test_has_ended_v;

  niosii_oci_dct_trace_capture #(
    .BUF_W(30), .CNT_W(4), .DEPTH(DEPTH), .STALL_ON_FULL(0), .DROP_W(16)
  ) u_drop (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  niosii_oci_dct_trace_capture #(
    .BUF_W(30), .CNT_W(4), .DEPTH(DEPTH), .STALL_ON_FULL(1), .DROP_W(16)
  ) u_stall (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  task automatic check_eq(input string name, input int m, input logic [63:0] act, input logic [63:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s dut%0d: got %0h, want %0h", name, m, act, exp);
  endtask

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      mcnt[m]   = 0;
      mdrop[m]  = 0;
      mstate[m] = 0;
      mdone[m]  = 1'b0;
      for (int i = 0; i < DEPTH; i++) mq[m][i] = '0;
    end
  endtask

  // Advance both models by one clock using the inputs currently driven.
  task automatic modelStep();
    bit wr_req, rd_fire, was_full, was_empty;
    for (int m = 0; m < 2; m++) begin
      wr_req    = dct_valid && (dct_cnt_v != 0) && (mstate[m] == 0);
      rd_fire   = (mcnt[m] > 0) && rd_ready_v;
      was_full  = (mcnt[m] == DEPTH);
      was_empty = (mcnt[m] == 0);
      if (rd_fire) begin
        for (int i = 0; i < DEPTH - 1; i++) mq[m][i] = mq[m][i+1];
        mcnt[m]--;
      end
      if (wr_req) begin
        if (!was_full || rd_fire) begin
          mq[m][mcnt[m]] = {dct_cnt_v, dct_buf_v};
          mcnt[m]++;
        end else if (m == 0 && mdrop[m] < DROP_MAX) begin
          mdrop[m]++;
        end
      end
      if (mstate[m] == 0 && (test_ending_v || test_has_ended_v)) begin
        mstate[m] = 1;
      end else if (mstate[m] == 1 && was_empty && test_has_ended_v) begin
        mstate[m] = 2;
        mdone[m]  = 1'b1;
      end
    end
  endtask

  task automatic check_bus(input int m, input logic stall, input logic rv, input logic [33:0] rd,
                           input logic [4:0] lvl, input logic [15:0] drop, input logic [1:0] st,
                           input logic done);
    logic [33:0] exp_data;
    exp_data = (mcnt[m] > 0) ? mq[m][0] : 34'd0;
    check_eq("rd_valid",    m, 64'(rv),    64'(mcnt[m] > 0));
    check_eq("rd_data",     m, 64'(rd),    64'(exp_data));
    check_eq("fifo_level",  m, 64'(lvl),   64'(mcnt[m]));
    check_eq("drop_count",  m, 64'(drop),  64'(mdrop[m]));
    check_eq("trace_state", m, 64'(st),    64'(mstate[m]));
    check_eq("trace_done",  m, 64'(done),  64'(mdone[m]));
    check_eq("dct_stall",   m, 64'(stall), 64'(m == 1 && mcnt[m] == DEPTH));
  endtask

  task automatic checkOutput();
    check_bus(0, bus0.dct_stall, bus0.rd_valid, bus0.rd_data, bus0.fifo_level, bus0.drop_count,
              bus0.trace_state, bus0.trace_done);
    check_bus(1, bus1.dct_stall, bus1.rd_valid, bus1.rd_data, bus1.fifo_level, bus1.drop_count,
              bus1.trace_state, bus1.trace_done);
  endtask

  // One clock: drive at the negedge, step the model, check at the following negedge.
  task automatic applyStimulus(input bit v, input logic [3:0] c, input bit rdy, input bit te, input bit the);
    dct_valid        = v;
    dct_cnt_v        = c;
    dct_buf_v        = 30'($urandom());
    rd_ready_v       = rdy;
    test_ending_v    = te;
    test_has_ended_v = the;
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    modelReset();
    @(negedge clk);
    checkOutput();
    reset = 1'b0;
  endtask

  initial begin
    modelReset();
    $display("[TB] start");
    repeat (2) @(negedge clk);
    checkOutput();
    check_eq("pin_reset_level", 0, 64'(bus0.fifo_level), 64'd0);
    check_eq("pin_reset_rdata", 0, 64'(bus0.rd_data), 64'd0);
    reset = 1'b0;

    // Three samples with counts 1..3 streamed through with the reader always ready.
    applyStimulus(1, 4'd1, 1, 0, 0);
    check_eq("pin_first_cnt", 0, 64'(bus0.rd_data[33:30]), 64'd1);
    applyStimulus(1, 4'd2, 1, 0, 0);
    applyStimulus(1, 4'd3, 1, 0, 0);
    repeat (3) applyStimulus(0, 4'd0, 1, 0, 0);
    check_eq("pin_t1_level", 0, 64'(bus0.fifo_level), 64'd0);
    check_eq("pin_t1_drop",  0, 64'(bus0.drop_count), 64'd0);

    // Twenty samples into a stalled reader: 4 dropped in drop mode, held off in stall mode.
    for (int i = 0; i < 20; i++) applyStimulus(1, 4'((i % 15) + 1), 0, 0, 0);
    check_eq("pin_t2_level", 0, 64'(bus0.fifo_level), 64'd16);
    check_eq("pin_t2_drop",  0, 64'(bus0.drop_count), 64'd4);
    check_eq("pin_t2_level", 1, 64'(bus1.fifo_level), 64'd16);
    check_eq("pin_t2_stall", 1, 64'(bus1.dct_stall),  64'd1);

    applyStimulus(1, 4'd5, 1, 0, 0);
    check_eq("pin_t3_level", 1, 64'(bus1.fifo_level), 64'd16);
    check_eq("pin_t3_stall", 1, 64'(bus1.dct_stall),  64'd1);

    applyStimulus(1, 4'd0, 0, 0, 0);
    check_eq("pin_t4_level", 0, 64'(bus0.fifo_level), 64'd16);
    check_eq("pin_t4_drop",  0, 64'(bus0.drop_count), 64'd4);

    repeat (DEPTH + 2) applyStimulus(0, 4'd0, 1, 0, 0);
    check_eq("pin_drain_level", 0, 64'(bus0.fifo_level), 64'd0);

    // Random traffic: a congested phase with a slow reader, then a mostly-ready phase.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 9) < ((i < 300) ? 3 : 8), 0, 0);
    end

    // Flush sequence: the write in the test_ending cycle is still stored.
    pulseReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, 4'(i + 1), 0, 0, 0);
    applyStimulus(1, 4'd9, 0, 1, 0);
    check_eq("pin_t5_state", 0, 64'(bus0.trace_state), 64'd1);
    check_eq("pin_t5_level", 0, 64'(bus0.fifo_level),  64'd5);
    repeat (3) applyStimulus(1, 4'd7, 0, 1, 0);
    check_eq("pin_t5_ignored", 0, 64'(bus0.fifo_level), 64'd5);
    repeat (5) applyStimulus(0, 4'd0, 1, 0, 0);
    check_eq("pin_t5_empty", 0, 64'(bus0.rd_valid), 64'd0);
    applyStimulus(0, 4'd0, 0, 0, 1);
    check_eq("pin_t5_done",  0, 64'(bus0.trace_done),  64'd1);
    check_eq("pin_t5_dstate", 0, 64'(bus0.trace_state), 64'd2);
    repeat (3) applyStimulus(1, 4'd3, 1, 0, 0);
    check_eq("pin_t5_sticky", 0, 64'(bus0.trace_done), 64'd1);

    // Asynchronous reset in the middle of a flush with seven entries queued.
    pulseReset();
    for (int i = 0; i < 7; i++) applyStimulus(1, 4'(i + 1), 0, 0, 0);
    applyStimulus(0, 4'd0, 0, 1, 0);
    check_eq("pin_t6_pre", 0, 64'(bus0.fifo_level), 64'd7);
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput();
    check_eq("pin_t6_level", 0, 64'(bus0.fifo_level),  64'd0);
    check_eq("pin_t6_state", 0, 64'(bus0.trace_state), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom_range(0, 1) != 0, 4'($urandom_range(0, 15)), $urandom_range(0, 1) != 0, 0, 0);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
